led_pattern_sequencer: RTL

// Drives one MKR header LED pin (bMKR_D[6]) with a programmable on/off pattern and PWM brightness.

---
 rtl/led_pattern_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
//
// Drives one header LED pin with a programmable 1..16 step on/off pattern.
// Each step lasts TICK_DIV clock cycles. During "on" steps the LED is gated
// by an 8-bit PWM. Pattern, length and duty sit in shadow registers. They
// reach the active set only at a pattern wrap, or at any cycle while the
// sequencer is idle, so a running pattern never shows a torn update.
//
// Ports
//   iCLK      in   1   fabric clock
//   iRESET    in   1   synchronous active-high reset (drops pending loads)
//   iEN       in   1   1 = run sequence, 0 = stop with LED off
//   iPATTERN  in  16   pattern bits, bit n drives step n
//   iPAT_LEN  in   4   last step index (length = iPAT_LEN + 1)
//   iDUTY     in   8   PWM brightness, 0 = off, 255 = fully on
//   iLOAD     in   1   strobe capturing iPATTERN/iPAT_LEN/iDUTY into shadow
//   oLED      out  1   LED drive (registered)
//   oSTEP     out  4   current step index
//   oWRAP     out  1   one-cycle pulse, coincident with oSTEP returning to 0
//   oPENDING  out  1   shadow loaded but not yet applied
// -----------------------------------------------------------------------------
module led_pattern_sequencer #(
  parameter int unsigned TICK_DIV = 8_000_000
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic        iEN,
  input  logic [15:0] iPATTERN,
  input  logic [3:0]  iPAT_LEN,
  input  logic [7:0]  iDUTY,
  input  logic        iLOAD,
  output logic        oLED,
  output logic [3:0]  oSTEP,
  output logic        oWRAP,
  output logic        oPENDING
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    PWM_LAST   = 8'd254;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [7:0]     pwm_q, pwm_d;
  logic [3:0]     step_q, step_d;
  logic           wrap_q, wrap_d;
  logic           led_q, led_d;
  logic           pend_q, pend_d;
  logic [15:0]    act_pat_q, act_pat_d;
  logic [3:0]     act_len_q, act_len_d;
  logic [7:0]     act_duty_q, act_duty_d;
  logic [15:0]    sh_pat_q, sh_pat_d;
  logic [3:0]     sh_len_q, sh_len_d;
  logic [7:0]     sh_duty_q, sh_duty_d;

  logic           tick_s;
  logic           apply_s;
  logic           pwm_on_s;

  // Sequencing: FSM, prescaler, PWM counter, step advance and LED decision.
  always_comb begin
    state_d  = state_q;
    presc_d  = '0;
    pwm_d    = 8'd0;
    step_d   = step_q;
    wrap_d   = 1'b0;
    led_d    = 1'b0;
    tick_s   = 1'b0;
    apply_s  = 1'b0;
    pwm_on_s = (pwm_q < act_duty_q);

    case (state_q)
      ST_IDLE: begin
        // Idle applies any pending shadow immediately.
        apply_s = pend_q;
        if (iEN) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (iEN) begin
          state_d = ST_RUN;
          tick_s  = (presc_q == PRESC_LAST);
          if (tick_s) begin
            presc_d = '0;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (pwm_q == PWM_LAST) begin
            pwm_d = 8'd0;
          end else begin
            pwm_d = pwm_q + 8'd1;
          end
          led_d = act_pat_q[step_q] & pwm_on_s;
          if (tick_s) begin
            // Equality compare only: a step beyond the length keeps counting.
            if (step_q == act_len_q) begin
              step_d  = 4'd0;
              wrap_d  = 1'b1;
              apply_s = pend_q;
            end else begin
              step_d  = step_q + 4'd1;
            end
          end else begin
            step_d = step_q;
          end
        end else begin
          // Leaving RUN: counters clear, LED goes dark next cycle.
          state_d = ST_IDLE;
          step_d  = 4'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        step_d  = 4'd0;
      end
    endcase

    // Shadow-to-active transfer. A shorter applied length must not strand
    // the step index beyond the new end of the pattern.
    act_pat_d  = act_pat_q;
    act_len_d  = act_len_q;
    act_duty_d = act_duty_q;
    pend_d     = pend_q;
    if (apply_s) begin
      act_pat_d  = sh_pat_q;
      act_len_d  = sh_len_q;
      act_duty_d = sh_duty_q;
      pend_d     = 1'b0;
      if (sh_len_q < step_d) begin
        step_d = 4'd0;
      end else begin
        step_d = step_d;
      end
    end else begin
      pend_d = pend_q;
    end

    // A load after the apply above keeps the new capture pending.
    sh_pat_d  = sh_pat_q;
    sh_len_d  = sh_len_q;
    sh_duty_d = sh_duty_q;
    if (iLOAD) begin
      sh_pat_d  = iPATTERN;
      sh_len_d  = iPAT_LEN;
      sh_duty_d = iDUTY;
      pend_d    = 1'b1;
    end else begin
      sh_pat_d  = sh_pat_q;
    end
  end

  // State registers with synchronous reset to the default single-step pattern.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      pwm_q      <= 8'd0;
      step_q     <= 4'd0;
      wrap_q     <= 1'b0;
      led_q      <= 1'b0;
      pend_q     <= 1'b0;
      act_pat_q  <= 16'h0001;
      act_len_q  <= 4'd0;
      act_duty_q <= 8'd255;
      sh_pat_q   <= 16'h0001;
      sh_len_q   <= 4'd0;
      sh_duty_q  <= 8'd255;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      pwm_q      <= pwm_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      led_q      <= led_d;
      pend_q     <= pend_d;
      act_pat_q  <= act_pat_d;
      act_len_q  <= act_len_d;
      act_duty_q <= act_duty_d;
      sh_pat_q   <= sh_pat_d;
      sh_len_q   <= sh_len_d;
      sh_duty_q  <= sh_duty_d;
    end
  end

  assign oLED     = led_q;
  assign oSTEP    = step_q;
  assign oWRAP    = wrap_q;
  assign oPENDING = pend_q;

endmodule
